// File: rtl/wb_queue_if.sv
// Handshake, write-port and forwarding-lookup bundle for the writeback queue.
// The master side is the producer/decode side; the slave side is the queue.
interface wb_queue_if #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
);
   logic                         in_valid;
   logic                         in_ready;
   logic [4:0]                   in_rd;
   logic [XLEN-1:0]              in_data;
   logic                         RegWrite;
   logic [4:0]                   rd;
   logic [XLEN-1:0]              Rd;
   logic [4:0]                   rs1;
   logic [4:0]                   rs2;
   logic                         hit1;
   logic                         hit2;
   logic [XLEN-1:0]              fwd1;
   logic [XLEN-1:0]              fwd2;
   logic [$clog2(DEPTH+1)-1:0]   count;

   modport master (
      output in_valid, in_rd, in_data, rs1, rs2,
      input  in_ready, RegWrite, rd, Rd, hit1, hit2, fwd1, fwd2, count
   );

   modport slave (
      input  in_valid, in_rd, in_data, rs1, rs2,
      output in_ready, RegWrite, rd, Rd, hit1, hit2, fwd1, fwd2, count
   );
endinterface

// File: rtl/wb_queue.sv
// In-order writeback FIFO draining one entry per cycle into the register file,
// with youngest-wins forwarding lookups. Define WBQ_INPUT_FWD_EN to also forward the incoming result.
module wb_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic       clk,
   input  logic       rst,
   wb_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

`ifdef WBQ_INPUT_FWD_EN
   localparam bit INPUT_FWD = 1'b1;
`else
   localparam bit INPUT_FWD = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   cnt;
   logic            push;
   logic            pop;

   assign bus.in_ready = (cnt < CW'(DEPTH));
   // x0 results complete the handshake but never occupy an entry.
   assign push = bus.in_valid && bus.in_ready && (bus.in_rd != 5'd0);
   assign pop  = (cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         vld  <= '0;
      end else begin
         if (pop) begin
            vld[head] <= 1'b0;
            head      <= head + PW'(1);
         end
         if (push) begin
            vld[tail] <= 1'b1;
            tail      <= tail + PW'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= '{rd: bus.in_rd, data: bus.in_data};
   end

   assign bus.count    = cnt;
   assign bus.RegWrite = pop;
   assign bus.rd       = pop ? mem[head].rd   : 5'd0;
   assign bus.Rd       = pop ? mem[head].data : '0;

   logic            h1, h2;
   logic [XLEN-1:0] f1, f2;
   logic [PW-1:0]   idx;

   // Walk from head toward tail so later (younger) matches override older ones.
   always_comb begin
      h1  = 1'b0;
      h2  = 1'b0;
      f1  = '0;
      f2  = '0;
      idx = head;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (vld[idx] && bus.rs1 != 5'd0 && mem[idx].rd == bus.rs1) begin
            h1 = 1'b1;
            f1 = mem[idx].data;
         end
         if (vld[idx] && bus.rs2 != 5'd0 && mem[idx].rd == bus.rs2) begin
            h2 = 1'b1;
            f2 = mem[idx].data;
         end
      end
      if (INPUT_FWD && push && bus.in_rd == bus.rs1) begin
         h1 = 1'b1;
         f1 = bus.in_data;
      end
      if (INPUT_FWD && push && bus.in_rd == bus.rs2) begin
         h2 = 1'b1;
         f2 = bus.in_data;
      end
   end

   assign bus.hit1 = h1;
   assign bus.hit2 = h2;
   assign bus.fwd1 = f1;
   assign bus.fwd2 = f2;
endmodule
